// File: rtl/dp_pattern_gen.sv
// Video timing and test-pattern generator: raster counters, sync/den timing and four
// selectable patterns, emitted as a registered 27-bit pixel word.
module dp_pattern_gen #(
    parameter int unsigned H_ACTIVE = 8,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 2,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 4,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 1,
    parameter int unsigned V_BP     = 1,
    parameter int unsigned BAR_W    = 1,
    parameter int unsigned CK_SH    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  Pattern,
    output logic [26:0] DPo,
    output logic        busy,
    output logic [7:0]  frame_cnt
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are wide enough for the raster, the ramp byte and the checker bit.
    localparam int unsigned HW0 = $clog2(H_TOTAL);
    localparam int unsigned HW1 = (HW0 > 8) ? HW0 : 8;
    localparam int unsigned HW  = (HW1 > CK_SH) ? HW1 : CK_SH + 1;
    localparam int unsigned VW0 = ($clog2(V_TOTAL) > 0) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned VW  = (VW0 > CK_SH) ? VW0 : CK_SH + 1;
    localparam int unsigned BW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q;
    logic [HW-1:0] hcnt_q;
    logic [VW-1:0] vcnt_q;
    logic [1:0]    pat_q;
    logic [2:0]    bar_q;
    logic [BW-1:0] bar_cnt_q;
    logic [7:0]    frame_cnt_q;
    logic [26:0]   dpo_q;
    logic          busy_q;

    logic          h_last, frame_last, den, hsync, vsync;
    logic [2:0]    code;
    logic [23:0]   rgb;
    logic [26:0]   pix;

    assign h_last     = (hcnt_q == H_LAST);
    assign frame_last = h_last && (vcnt_q == V_LAST);
    assign den        = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hsync      = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    assign vsync      = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

    always_comb begin
        code = 3'd0;
        rgb  = '0;
        case (pat_q)
            2'b00: begin
                code = 3'd7 - bar_q;
                rgb  = {{8{code[2]}}, {8{code[1]}}, {8{code[0]}}};
            end
            2'b01: rgb = {3{hcnt_q[7:0]}};
            2'b10: begin
                code = frame_cnt_q[2:0];
                rgb  = {{8{code[2]}}, {8{code[1]}}, {8{code[0]}}};
            end
            default: rgb = {24{hcnt_q[CK_SH] ^ vcnt_q[CK_SH] ^ frame_cnt_q[0]}};
        endcase
        if (!den) rgb = '0;
        pix = {vsync, hsync, den, rgb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            pat_q       <= 2'b00;
            bar_q       <= '0;
            bar_cnt_q   <= '0;
            frame_cnt_q <= '0;
            dpo_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Counters already sit at (0,0); the first RUN cycle holds that pixel.
                    if (en) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        pat_q   <= Pattern;
                    end
                end
                default: begin
                    dpo_q <= pix;
                    if (frame_last) begin
                        hcnt_q      <= '0;
                        vcnt_q      <= '0;
                        bar_q       <= '0;
                        bar_cnt_q   <= '0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        if (en) begin
                            pat_q <= Pattern;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            dpo_q   <= '0;
                        end
                    end else if (h_last) begin
                        hcnt_q    <= '0;
                        vcnt_q    <= vcnt_q + 1'b1;
                        bar_q     <= '0;
                        bar_cnt_q <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                        if (bar_cnt_q == BAR_LAST) begin
                            bar_cnt_q <= '0;
                            bar_q     <= bar_q + 3'd1;
                        end else begin
                            bar_cnt_q <= bar_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign DPo       = dpo_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/dp_pattern_gen.md
DP_PATTERN_GEN -- requirements
Module: dp_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACTIVE 8, active pixels per line
  H_FP 2, horizontal front porch (clocks)
  H_SYNC 2, hsync width (clocks)
  H_BP 2, horizontal back porch (clocks)
  V_ACTIVE 4, active lines per frame
  V_FP 1, vertical front porch (lines)
  V_SYNC 1, vsync width (lines)
  V_BP 1, vertical back porch (lines)
  BAR_W 1, color-bar width (active pixels)
  CK_SH 1, checker cell size = 2^CK_SH pixels/lines
REQ-002 Ports (name, direction, width, meaning), one per line; single clock, reset asynchronous active-low:
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  en  in  1  run request, sampled at frame boundaries only
  Pattern  in  2  pattern select, latched at frame start
  DPo  out  27  {vsync,hsync,den,R[7:0],G[7:0],B[7:0]}, drives a pixel-stream DPi input
  busy  out  1  high while in RUN
  frame_cnt  out  8  completed-frame counter

Function
REQ-003 SHALL implement FSM IDLE/RUN; IDLE->RUN when en=1 in IDLE; RUN->IDLE only at last frame cycle (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) with en=0; else RUN continues into the next frame.
REQ-004 SHALL keep hcnt in 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; in RUN, hcnt SHALL increment each clock and wrap to 0; vcnt (0..V_TOTAL-1) SHALL increment on hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-005 In IDLE, hcnt=vcnt=0 held; DPo=0; busy=0.
REQ-006 Pattern SHALL be latched into pat_r on the clock entering pixel (0,0) from IDLE or from frame wrap; mid-frame Pattern changes SHALL have no effect.
REQ-007 den=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE; hsync=1 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, on every line; vsync=1 for all clocks of lines V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC; syncs active-high.
REQ-008 DPo SHALL be registered: DPo at edge k reflects (hcnt,vcnt) held in cycle k-1 (latency 1); first clock of RUN holds (0,0).
REQ-009 When den=0, R=G=B=0.
REQ-010 Color code c[2:0] -> R={8{c[2]}}, G={8{c[1]}}, B={8{c[0]}}.
REQ-011 pat_r=00 color bars: bar index b increments every BAR_W active pixels, wraps 7->0, resets to 0 at each line start; c=7-b (white first).
REQ-012 pat_r=01 ramp: R=G=B=hcnt[7:0].
REQ-013 pat_r=10 aging: whole-frame solid color, c=frame_cnt[2:0].
REQ-014 pat_r=11 checker: hcnt[CK_SH]^vcnt[CK_SH]^frame_cnt[0]=1 -> FFFFFF, else 000000.
REQ-015 frame_cnt SHALL increment by 1 on each last frame cycle in RUN, 8-bit wrap 255->0, unaffected by en.
REQ-016 busy SHALL be registered, =1 from the edge entering RUN until the edge returning to IDLE.

Reset
REQ-017 rst_n=0 SHALL immediately force DPo=0, busy=0, frame_cnt=0, hcnt=vcnt=0, pat_r=00, state IDLE, including mid-frame.
REQ-018 After rst_n release, no output changes until en=1 is sampled.

Verification
REQ-019 Reset, en=1, Pattern=00, defaults -> first edge after RUN entry DPo=27'h1FFFFFF; pixels 0..7 codes 7..0; pixel 7 DPo=27'h1000000.
REQ-020 RUN, defaults -> hsync=1 only for hcnt 10,11 each line; vsync=1 only on line 5; den pulses 4 lines x 8 pixels; frame period 98 clocks.
REQ-021 Pattern 01->11 at vcnt=2 -> current frame stays ramp (R=G=B=0..7); next frame is checker, pixel (0,0)=FFFFFF since frame_cnt[0]=1.
REQ-022 en=0 mid-frame -> frame completes; frame_cnt increments; busy=0 and DPo=0 from next edge; en=0 for 300 clocks -> frame_cnt unchanged.
REQ-023 Pattern=10, run 257 frames -> solid colors cycle 000000, 0000FF, 00FF00 ... per frame; frame_cnt wraps to 1 after 257th frame.
REQ-024 rst_n low at hcnt=5, vcnt=2 -> DPo=0, frame_cnt=0 same cycle; restart begins at (0,0).
